// File: rtl/mont_pkg.sv
// ----------------------------------------------------------------------------
// mont_pkg
// Shared constants and types for the word-serial Montgomery reduction
// sequencer (mont_redc_32_seq) and its q x M sub-module (mont_qxm_word).
//
// Contents:
//   W, N, ITERS       word width, modulus width, reduction iterations
//   ACC_W, QM_W       accumulator width (2N+1) and q*M product width (W+N)
//   M                 256-bit modulus constant
//   M_SH_*            bit positions of the sparse signed-power-of-two form of M
//   state_t           sequencer states
//   word_t, acc_t,    datapath types
//   qm_t, cnt_t
//
// Configuration macro used by the design: MONT_FINAL_SUB_EN
// ----------------------------------------------------------------------------
package mont_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned N     = 256;
    localparam int unsigned ITERS = N / W;
    localparam int unsigned ACC_W = 2 * N + 1;
    localparam int unsigned QM_W  = W + N;
    localparam int unsigned CNT_W = $clog2(ITERS);

    // M = 2^255 - 2^224 + 2^192 + 2^96 - 1
    // Low word is all ones, so -M^-1 mod 2^32 == 1 and q is simply acc[31:0].
    // M < 2^255, hence 2M < 2^256 and an unreduced result still fits in N bits.
    localparam int unsigned M_SH_TOP = 255;
    localparam int unsigned M_SH_NEG = 224;
    localparam int unsigned M_SH_MID = 192;
    localparam int unsigned M_SH_LOW = 96;

    localparam logic [N-1:0] M =
        256'h7FFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FSUB = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [W-1:0]     word_t;
    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [QM_W-1:0]  qm_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mont_qxm_word.sv
// ----------------------------------------------------------------------------
// mont_qxm_word
// Combinational multiply of one 32-bit quotient word by the fixed modulus M.
// M is sparse (four signed powers of two plus -1), so the product is built
// from shifted copies of q instead of a general 32x256 multiplier.
//
// Ports:
//   q_i     in   W       quotient word
//   prod_o  out  W+N     q * M (full width; the product needs W+N bits)
// ----------------------------------------------------------------------------
module mont_qxm_word
    import mont_pkg::*;
(
    input  logic [W-1:0]    q_i,
    output logic [QM_W-1:0] prod_o
);

    qm_t q_ext;
    qm_t pos_sum;
    qm_t neg_sum;

    always_comb begin
        q_ext   = qm_t'(q_i);
        // Positive terms: 2^255, 2^192, 2^96. Negative terms: 2^224, 1.
        pos_sum = (q_ext << M_SH_TOP) + (q_ext << M_SH_MID) + (q_ext << M_SH_LOW);
        neg_sum = (q_ext << M_SH_NEG) + q_ext;
        // True product is non-negative and < 2^(W+N), so modular wrap is exact.
        prod_o  = pos_sum - neg_sum;
    end

endmodule

// File: rtl/mont_redc_32_seq.sv
// ----------------------------------------------------------------------------
// mont_redc_32_seq
// Word-serial Montgomery reduction: R = T * 2^-256 mod M for a 512-bit T.
// Each ITER cycle takes q = acc[31:0], adds q*M (which zeroes the low word)
// and shifts the accumulator right by one word; eight iterations divide by
// 2^256. One operand in flight at a time.
//
// Ports:
//   clk        in   1    system clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    T operand valid
//   in_ready   out  1    high only in IDLE
//   t_in       in   512  product to reduce (T < M*2^256)
//   out_valid  out  1    result valid (DONE state)
//   out_ready  in   1    downstream accepts result
//   r_out      out  256  reduced result, held stable until handshake
//   busy       out  1    high in any state other than IDLE
//
// Configuration macro: MONT_FINAL_SUB_EN
//   defined   - FSUB state performs the conditional subtract, r_out in [0, M)
//   undefined - no FSUB, r_out in [0, 2M), one cycle less latency
// ----------------------------------------------------------------------------
module mont_redc_32_seq
    import mont_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] t_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   r_out,
    output logic           busy
);

    state_t       state_q, state_d;
    acc_t         acc_q,   acc_d;
    cnt_t         cnt_q,   cnt_d;
    logic [N-1:0] r_q,     r_d;

    word_t        q_word;
    qm_t          qm;
    acc_t         sum;
    logic         last_iter;
    logic         accept;

`ifdef MONT_FINAL_SUB_EN
    acc_t         acc_minus_m;
`endif

    // ------------------------------------------------------------------
    // q * M
    // ------------------------------------------------------------------
    assign q_word = acc_q[W-1:0];

    mont_qxm_word u_qxm (
        .q_i    (q_word),
        .prod_o (qm)
    );

    always_comb begin
        sum       = acc_q + acc_t'(qm);
        last_iter = (cnt_q == cnt_t'(ITERS - 1));
        accept    = in_valid && in_ready;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
`ifdef MONT_FINAL_SUB_EN
                    state_d = FSUB;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef MONT_FINAL_SUB_EN
            FSUB: begin
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure state decode)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    assign r_out = r_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
`ifdef MONT_FINAL_SUB_EN
    always_comb begin
        acc_minus_m = acc_q - acc_t'(M);
    end
`endif

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        r_d   = r_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = {1'b0, t_in};
                    cnt_d = '0;
                end
            end
            ITER: begin
                acc_d = sum >> W;
                cnt_d = cnt_q + 1'b1;
`ifndef MONT_FINAL_SUB_EN
                // Without the final subtract the shifted sum is the result.
                if (last_iter) begin
                    r_d = sum[W +: N];
                end
`endif
            end
`ifdef MONT_FINAL_SUB_EN
            FSUB: begin
                r_d = (acc_q >= acc_t'(M)) ? acc_minus_m[N-1:0] : acc_q[N-1:0];
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            r_q   <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            r_q   <= r_d;
        end
    end

    // ------------------------------------------------------------------
    // Adding q*M must always clear the low word before the shift.
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_low_word_zero: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == ITER) |-> (sum[W-1:0] == '0)
    ) else $error("mont_redc_32_seq: low accumulator word not zero after q*M add");
`endif

endmodule

// File: tb/tb_mont_redc_32_seq.sv
module tb_mont_redc_32_seq;

    localparam logic [255:0] MOD =
        256'h7FFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

`ifdef MONT_FINAL_SUB_EN
    localparam bit          FSUB_ON = 1'b1;
    localparam int unsigned LAT     = 9;
`else
    localparam bit          FSUB_ON = 1'b0;
    localparam int unsigned LAT     = 8;
`endif

    localparam int unsigned N_RAND = 1500;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [511:0] t_in      = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [255:0] r_out;

    int unsigned  checks = 0;
    int unsigned  fails  = 0;

    logic [255:0] exp_q[$];

    mont_redc_32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .t_in      (t_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Bit-serial Montgomery: add M when odd, halve; 256 times divides by 2^256.
    // The multiple of M added is the unique k < 2^256 clearing the low 256 bits,
    // so the unreduced value equals the word-serial unreduced value.
    function automatic logic [256:0] model_raw(input logic [511:0] t);
        logic [512:0] x;
        x = {1'b0, t};
        for (int i = 0; i < 256; i++) begin
            if (x[0]) x = x + {257'b0, MOD};
            x = x >> 1;
        end
        return x[256:0];
    endfunction

    function automatic logic [255:0] model(input logic [511:0] t);
        logic [256:0] raw;
        raw = model_raw(t);
        if (FSUB_ON && raw >= {1'b0, MOD}) raw = raw - {1'b0, MOD};
        return raw[255:0];
    endfunction

    function automatic logic [511:0] rand_t();
        logic [511:0] t;
        logic [511:0] lim;
        for (int i = 0; i < 16; i++) t[32*i +: 32] = $urandom();
        t[511] = 1'b0;
        lim = {MOD, 256'b0};
        if (t >= lim) t = t - lim;
        return t;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_congruent(input string tag, input logic [255:0] r, input logic [511:0] t);
        logic [767:0] lhs;
        logic [767:0] rhs;
        lhs = {256'b0, r, 256'b0} % {512'b0, MOD};
        rhs = {256'b0, t} % {512'b0, MOD};
        check(tag, lhs[511:0], rhs[511:0]);
    endtask

    // Present t, wait (bounded) for in_ready, return at the negedge after accept.
    task automatic send(input logic [511:0] t);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        t_in     = t;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept", {511'b0, in_ready}, 512'd1);
        exp_q.push_back(model(t));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Entered at the negedge right after accept. Checks latency, holds
    // out_ready low for 'stall' cycles, then completes the handshake.
    task automatic receive(input string tag, input int unsigned stall, input bit full,
                           input logic [511:0] t);
        int unsigned  c;
        logic [255:0] held;
        logic [255:0] e;
        c = 0;
        while (!out_valid && c < 30) begin
            check({tag, "_busy"}, {510'b0, busy, in_ready}, 512'd2);
            @(negedge clk);
            c++;
        end
        check({tag, "_latency"}, 512'(c), 512'(LAT));
        held = r_out;
        for (int unsigned s = 0; s < stall; s++) begin
            check({tag, "_hold_flags"}, {509'b0, out_valid, busy, in_ready}, 512'd6);
            check({tag, "_hold_r"}, {256'b0, r_out}, {256'b0, held});
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard"}, 512'(exp_q.size()), 512'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_r"}, {256'b0, r_out}, {256'b0, e});
        end
        if (full) begin
            check({tag, "_range"}, {511'b0, FSUB_ON ? ({1'b0, r_out} < {1'b0, MOD})
                                                    : ({1'b0, r_out} < ({1'b0, MOD} << 1))},
                  512'd1);
            check_congruent({tag, "_congruent"}, r_out, t);
        end
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, {509'b0, out_valid, busy, in_ready}, 512'd1);
    endtask

    initial begin
        logic [511:0] t;
        logic [511:0] t2;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  {511'b0, in_ready},  512'd1);
        check("rst_out_valid", {511'b0, out_valid}, 512'd0);
        check("rst_busy",      {511'b0, busy},      512'd0);
        check("rst_r_out",     {256'b0, r_out},     512'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands
        send('0);                       receive("t_zero", 0, 1'b1, '0);
        send(512'd1);                   receive("t_one", 0, 1'b1, 512'd1);
        t = {256'b0, MOD};
        send(t);                        receive("t_mod", 0, 1'b1, t);
        t = {MOD, 256'b0} - 512'd1;
        send(t);                        receive("t_max", 0, 1'b1, t);
        t = {128'h0123456789ABCDEF_FEDCBA9876543210, 128'hDEADBEEF_CAFEF00D_00000001_80000000,
             128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0};
        send(t);                        receive("t_mix", 0, 1'b1, t);

        // Back-pressure: second operand presented while busy must be ignored
        t  = rand_t();
        t2 = rand_t();
        send(t);
        in_valid = 1'b1;
        t_in     = t2;
        receive("bp_first", 5, 1'b1, t);
        send(t2);
        receive("bp_second", 0, 1'b1, t2);

        // Reset in the middle of iteration
        send(rand_t());
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  {511'b0, in_ready},  512'd1);
        check("midrst_out_valid", {511'b0, out_valid}, 512'd0);
        check("midrst_busy",      {511'b0, busy},      512'd0);
        check("midrst_r_out",     {256'b0, r_out},     512'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(512'h1234_5678);
        receive("after_rst", 0, 1'b1, 512'h1234_5678);

        // Random regression with random stalls
        for (int unsigned i = 0; i < N_RAND; i++) begin
            t = rand_t();
            send(t);
            receive("rand", $urandom_range(0, 3), 1'b0, t);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
